// File: rtl/bs_packer.sv
// rtl/bs_packer.sv - LSB-first variable-length token packer for the deflate bitstream path
module bs_packer #(
  parameter  int IN_WD  = 19,
  parameter  int OUT_WD = 32,
  parameter  int CNT_WD = 32,
  localparam int NB_WD  = $clog2(IN_WD + 1),
  localparam int BY_WD  = $clog2(OUT_WD / 8 + 1),
  localparam int ACC_WD = OUT_WD + IN_WD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              in_val_i,
  output logic              in_rdy_o,
  input  logic [IN_WD-1:0]  in_dat_i,
  input  logic [NB_WD-1:0]  in_numb_i,
  input  logic [1:0]        in_cmd_i,
  output logic              out_val_o,
  input  logic              out_rdy_i,
  output logic [OUT_WD-1:0] out_dat_o,
  output logic [BY_WD-1:0]  out_nbyte_o,
  output logic              out_lst_o,
  output logic [CNT_WD-1:0] byte_cnt_o,
  output logic              done_o
);

  // Fill can briefly exceed ACC_WD by the byte padding (padding bits are
  // implicit zeros above the stored accumulator), so size it with headroom.
  localparam int                FL_WD   = $clog2(ACC_WD + 8);
  localparam logic [FL_WD-1:0]  OUT_FL  = FL_WD'(OUT_WD);
  localparam logic [NB_WD-1:0]  IN_MAX  = NB_WD'(IN_WD);
  localparam logic [BY_WD-1:0]  FULL_NB = BY_WD'(OUT_WD / 8);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_WD-1:0]  acc_q;
  logic [ACC_WD-1:0]  acc_m;
  logic [ACC_WD-1:0]  acc_d;
  logic [ACC_WD-1:0]  tok;
  logic [FL_WD-1:0]   fill_q;
  logic [FL_WD-1:0]   fill_m;
  logic [FL_WD-1:0]   fill_sum;
  logic [FL_WD-1:0]   fill_d;
  logic [NB_WD-1:0]   n_eff;
  logic               out_free;
  logic               out_hs;
  logic               lst_pending;
  logic               accept;
  logic               is_flush;
  logic               is_pad;
  logic               move;
  logic               move_lst;

  assign in_rdy_o    = (state_q == ST_RUN) && (fill_q < OUT_FL);
  assign accept      = in_val_i && in_rdy_o;
  assign out_hs      = out_val_o && out_rdy_i;
  assign out_free    = !out_val_o || out_rdy_i;
  assign lst_pending = out_val_o && out_lst_o;
  assign is_flush    = (in_cmd_i == 2'd2);
  assign is_pad      = (in_cmd_i == 2'd1) || (in_cmd_i == 2'd2);

  // State register: RUN accepts tokens, DRAIN empties the accumulator after FLUSH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
    end else if (clr_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and word-move decision; in DRAIN the move that leaves at most
  // one word of bits is the final one, and no further move happens until it is taken.
  always_comb begin
    state_d  = state_q;
    move     = 1'b0;
    move_lst = 1'b0;
    case (state_q)
      ST_RUN: begin
        if ((fill_q >= OUT_FL) && out_free) begin
          move = 1'b1;
        end
        if (accept && is_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_free && !lst_pending) begin
          move     = 1'b1;
          move_lst = (fill_q <= OUT_FL);
        end
        if (out_hs && out_lst_o) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Accumulator update: word move first, then token insert at the new fill, then padding.
  always_comb begin
    acc_m  = acc_q;
    fill_m = fill_q;
    if (move) begin
      acc_m  = acc_q >> OUT_WD;
      fill_m = move_lst ? '0 : (fill_q - OUT_FL);
    end
    n_eff    = (in_numb_i > IN_MAX) ? IN_MAX : in_numb_i;
    tok      = ACC_WD'(in_dat_i) & ~({ACC_WD{1'b1}} << n_eff);
    fill_sum = fill_m + FL_WD'(n_eff);
    acc_d    = acc_m;
    fill_d   = fill_m;
    if (accept) begin
      acc_d  = acc_m | (tok << fill_m);
      fill_d = is_pad ? ((fill_sum + FL_WD'(7)) & ~FL_WD'(7)) : fill_sum;
    end
  end

  // Datapath registers: accumulator, output word, byte counter and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      fill_q      <= '0;
      out_val_o   <= 1'b0;
      out_dat_o   <= '0;
      out_nbyte_o <= '0;
      out_lst_o   <= 1'b0;
      byte_cnt_o  <= '0;
      done_o      <= 1'b0;
    end else if (clr_i) begin
      acc_q       <= '0;
      fill_q      <= '0;
      out_val_o   <= 1'b0;
      out_dat_o   <= '0;
      out_nbyte_o <= '0;
      out_lst_o   <= 1'b0;
      byte_cnt_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      done_o <= out_hs && out_lst_o;
      if (out_hs) begin
        byte_cnt_o <= byte_cnt_o + CNT_WD'(out_nbyte_o);
      end
      if (move) begin
        out_val_o   <= 1'b1;
        out_dat_o   <= acc_q[OUT_WD-1:0];
        out_nbyte_o <= move_lst ? BY_WD'(fill_q >> 3) : FULL_NB;
        out_lst_o   <= move_lst;
      end else if (out_hs) begin
        out_val_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bs_packer.sv
// tb/tb_bs_packer.sv - self-checking bench for bs_packer
module tb_bs_packer;
  localparam int IN_WD  = 19;
  localparam int OUT_WD = 32;
  localparam int NB_WD  = 5;
  localparam int BY_WD  = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              clr_i = 1'b0;
  logic              in_val_i = 1'b0;
  logic              in_rdy_o;
  logic [IN_WD-1:0]  in_dat_i = '0;
  logic [NB_WD-1:0]  in_numb_i = '0;
  logic [1:0]        in_cmd_i = '0;
  logic              out_val_o;
  logic              out_rdy_i = 1'b0;
  logic [OUT_WD-1:0] out_dat_o;
  logic [BY_WD-1:0]  out_nbyte_o;
  logic              out_lst_o;
  logic [31:0]       byte_cnt_o;
  logic              done_o;

  logic              in_val5 = 1'b0;
  logic              in_rdy5;
  logic [IN_WD-1:0]  in_dat5 = '0;
  logic [NB_WD-1:0]  in_numb5 = '0;
  logic [1:0]        in_cmd5 = '0;
  logic              out_val5;
  logic              out_rdy5 = 1'b0;
  logic [63:0]       out_dat5;
  logic [3:0]        out_nbyte5;
  logic              out_lst5;
  logic [7:0]        byte_cnt5;
  logic              done5;

  always #5 clk = ~clk;

  bs_packer dut (
    .clk(clk), .rstn(rstn), .clr_i(clr_i),
    .in_val_i(in_val_i), .in_rdy_o(in_rdy_o), .in_dat_i(in_dat_i),
    .in_numb_i(in_numb_i), .in_cmd_i(in_cmd_i),
    .out_val_o(out_val_o), .out_rdy_i(out_rdy_i), .out_dat_o(out_dat_o),
    .out_nbyte_o(out_nbyte_o), .out_lst_o(out_lst_o),
    .byte_cnt_o(byte_cnt_o), .done_o(done_o)
  );

  bs_packer #(.IN_WD(19), .OUT_WD(64), .CNT_WD(8)) dut5 (
    .clk(clk), .rstn(rstn), .clr_i(clr_i),
    .in_val_i(in_val5), .in_rdy_o(in_rdy5), .in_dat_i(in_dat5),
    .in_numb_i(in_numb5), .in_cmd_i(in_cmd5),
    .out_val_o(out_val5), .out_rdy_i(out_rdy5), .out_dat_o(out_dat5),
    .out_nbyte_o(out_nbyte5), .out_lst_o(out_lst5),
    .byte_cnt_o(byte_cnt5), .done_o(done5)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  tq_cmd[$];
  int          tq_n[$];
  logic [18:0] tq_d[$];
  logic [31:0] ob_dat[$];
  int          ob_nb[$];
  bit          ob_ls[$];
  logic [31:0] ex_dat[$];
  int          ex_nb[$];
  bit          ex_ls[$];
  logic [31:0] exp_bytes = '0;

  typedef struct {
    int               ntok;
    logic [9:0][1:0]  cmd;
    logic [9:0][4:0]  n;
    logic [9:0][18:0] d;
    int               nw;
    logic [1:0][31:0] wd;
    logic [1:0][2:0]  nb;
    logic [1:0]       ls;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_tok(input int v, input int i, input logic [1:0] c, input int n, input logic [18:0] d);
    vt[v].cmd[i] = c;
    vt[v].n[i]   = 5'(n);
    vt[v].d[i]   = d;
  endtask

  task automatic set_word(input int v, input int k, input logic [31:0] w, input int nb, input bit ls);
    vt[v].wd[k] = w;
    vt[v].nb[k] = 3'(nb);
    vt[v].ls[k] = ls;
  endtask

  task automatic load_vec(input int v);
    tq_cmd.delete(); tq_n.delete(); tq_d.delete();
    for (int i = 0; i < vt[v].ntok; i++) begin
      tq_cmd.push_back(vt[v].cmd[i]);
      tq_n.push_back(int'(vt[v].n[i]));
      tq_d.push_back(vt[v].d[i]);
    end
  endtask

  task automatic gen_random(input int ntok);
    int r;
    tq_cmd.delete(); tq_n.delete(); tq_d.delete();
    for (int i = 0; i < ntok; i++) begin
      r = $urandom_range(99);
      if (i == ntok - 1) tq_cmd.push_back(2'd2);
      else if (r < 10)   tq_cmd.push_back(2'd1);
      else if (r < 15)   tq_cmd.push_back(2'd3);
      else               tq_cmd.push_back(2'd0);
      tq_n.push_back(($urandom_range(99) < 5) ? int'($urandom_range(31, 20)) : int'($urandom_range(19)));
      tq_d.push_back(19'($urandom));
    end
  endtask

  // Reference: the stream is one long bit sequence; the words are cut from it
  // by how many full words existed before FLUSH and by the drain rules.
  task automatic build_expected();
    bit q[$];
    int p, nn, nrun, rem, pos, nbits;
    bit lst;
    logic [31:0] w;
    ex_dat.delete(); ex_nb.delete(); ex_ls.delete();
    p = 0;
    foreach (tq_cmd[i]) begin
      nn = (tq_n[i] > IN_WD) ? IN_WD : tq_n[i];
      if (tq_cmd[i] == 2'd2) p = q.size();
      for (int b = 0; b < nn; b++) q.push_back(tq_d[i][b]);
      if (tq_cmd[i] == 2'd1 || tq_cmd[i] == 2'd2)
        while (q.size() % 8 != 0) q.push_back(1'b0);
    end
    nrun = p / OUT_WD;
    rem  = q.size() - nrun * OUT_WD;
    pos  = 0;
    while (1) begin
      if (nrun > 0) begin nbits = OUT_WD; nrun--; lst = 0; end
      else if (rem > OUT_WD) begin nbits = OUT_WD; rem -= OUT_WD; lst = 0; end
      else begin nbits = rem; lst = 1; end
      w = '0;
      for (int b = 0; b < nbits; b++) w[b] = q[pos + b];
      pos += nbits;
      ex_dat.push_back(w); ex_nb.push_back(nbits / 8); ex_ls.push_back(lst);
      if (lst) break;
    end
  endtask

  task automatic run_stream(input int rdy_pct, input int val_pct);
    int idx = 0;
    bit draining = 0, want_done = 0, got_done = 0;
    bit pv = 0, ph = 0, pl = 0;
    logic [31:0] pd = '0;
    logic [2:0]  pn = '0;
    ob_dat.delete(); ob_nb.delete(); ob_ls.delete();
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      @(negedge clk);
      if (pv && !ph) begin
        check("hold_val", out_val_o, 1);
        check("hold_dat", out_dat_o, pd);
        check("hold_nbyte", out_nbyte_o, pn);
        check("hold_lst", out_lst_o, pl);
      end
      if (want_done) begin
        check("done_pulse", done_o, 1);
        got_done = 1;
      end else begin
        check("done_idle", done_o, 0);
      end
      if (draining && !want_done) check("in_rdy_drain", in_rdy_o, 0);
      out_rdy_i = ($urandom_range(99) < rdy_pct);
      in_val_i  = (idx < tq_cmd.size()) && ($urandom_range(99) < val_pct);
      if (idx < tq_cmd.size()) begin
        in_cmd_i  = tq_cmd[idx];
        in_numb_i = NB_WD'(tq_n[idx]);
        in_dat_i  = tq_d[idx];
      end
      if (in_val_i && in_rdy_o) begin
        if (tq_cmd[idx] == 2'd2) draining = 1;
        idx++;
      end
      ph = out_val_o && out_rdy_i;
      pv = out_val_o; pd = out_dat_o; pn = out_nbyte_o; pl = out_lst_o;
      if (ph) begin
        ob_dat.push_back(out_dat_o); ob_nb.push_back(int'(out_nbyte_o)); ob_ls.push_back(out_lst_o);
        if (out_lst_o) want_done = 1;
      end
    end
    if (!got_done) check("stream_timeout", 0, 1);
    @(negedge clk);
    in_val_i  = 1'b0;
    out_rdy_i = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    build_expected();
    check({tag, "_nwords"}, ob_dat.size(), ex_dat.size());
    for (int k = 0; k < ex_dat.size() && k < ob_dat.size(); k++) begin
      check($sformatf("%s_w%0d_dat", tag, k), ob_dat[k], ex_dat[k]);
      check($sformatf("%s_w%0d_nbyte", tag, k), ob_nb[k], ex_nb[k]);
      check($sformatf("%s_w%0d_lst", tag, k), ob_ls[k], ex_ls[k]);
      exp_bytes += 32'(ex_nb[k]);
    end
    check({tag, "_byte_cnt"}, byte_cnt_o, exp_bytes);
  endtask

  task automatic feed_tokens(input int from, input int to, input bit rdy);
    int idx = from;
    for (int c = 0; c < 500 && idx < to; c++) begin
      @(negedge clk);
      out_rdy_i = rdy;
      in_val_i  = 1'b1;
      in_cmd_i  = tq_cmd[idx];
      in_numb_i = NB_WD'(tq_n[idx]);
      in_dat_i  = tq_d[idx];
      if (in_rdy_o) idx++;
    end
    @(negedge clk);
    in_val_i = 1'b0;
    check("feed_accepted", idx, to);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_val"}, out_val_o, 0);
    check({tag, "_out_dat"}, out_dat_o, 0);
    check({tag, "_out_nbyte"}, out_nbyte_o, 0);
    check({tag, "_out_lst"}, out_lst_o, 0);
    check({tag, "_byte_cnt"}, byte_cnt_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_in_rdy"}, in_rdy_o, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nw5, nb5_last;
    bit got5;

    vt[0].ntok = 2; set_tok(0, 0, 0, 3, 19'h7FFFB); set_tok(0, 1, 2, 0, 19'h12345);
    vt[0].nw = 1;   set_word(0, 0, 32'h00000003, 1, 1);
    vt[1].ntok = 9;
    for (int i = 0; i < 8; i++) set_tok(1, i, 0, 4, 19'h7FFFA);
    set_tok(1, 8, 2, 0, 19'h0);
    vt[1].nw = 2;   set_word(1, 0, 32'hAAAAAAAA, 4, 0); set_word(1, 1, 32'h0, 0, 1);
    vt[2].ntok = 4; set_tok(2, 0, 0, 1, 19'h1); set_tok(2, 1, 1, 0, 19'h7FFFF);
    set_tok(2, 2, 0, 8, 19'h000FF); set_tok(2, 3, 2, 0, 19'h0);
    vt[2].nw = 1;   set_word(2, 0, 32'h0000FF01, 2, 1);
    vt[3].ntok = 2; set_tok(3, 0, 0, 16, 19'h0BEEF); set_tok(3, 1, 2, 16, 19'h7DEAD);
    vt[3].nw = 1;   set_word(3, 0, 32'hDEADBEEF, 4, 1);
    vt[4].ntok = 4; set_tok(4, 0, 0, 8, 19'h0005A); set_tok(4, 1, 1, 0, 19'h0);
    set_tok(4, 2, 3, 8, 19'h000C3); set_tok(4, 3, 2, 0, 19'h0);
    vt[4].nw = 1;   set_word(4, 0, 32'h0000C35A, 2, 1);
    vt[5].ntok = 2; set_tok(5, 0, 0, 31, 19'h7FFFF); set_tok(5, 1, 2, 0, 19'h0);
    vt[5].nw = 1;   set_word(5, 0, 32'h0007FFFF, 3, 1);
    vt[6].ntok = 2; set_tok(6, 0, 0, 19, 19'h7FFFF); set_tok(6, 1, 2, 19, 19'h55555);
    vt[6].nw = 2;   set_word(6, 0, 32'hAAAFFFFF, 4, 0); set_word(6, 1, 32'h0000002A, 1, 1);

    repeat (2) @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      load_vec(v);
      run_stream(100, 100);
      check($sformatf("vec%0d_nwords", v), ob_dat.size(), vt[v].nw);
      for (int k = 0; k < vt[v].nw && k < ob_dat.size(); k++) begin
        check($sformatf("vec%0d_w%0d_dat", v, k), ob_dat[k], vt[v].wd[k]);
        check($sformatf("vec%0d_w%0d_nbyte", v, k), ob_nb[k], vt[v].nb[k]);
        check($sformatf("vec%0d_w%0d_lst", v, k), ob_ls[k], vt[v].ls[k]);
        exp_bytes += 32'(vt[v].nb[k]);
      end
      check($sformatf("vec%0d_byte_cnt", v), byte_cnt_o, exp_bytes);
    end

    for (int s = 0; s < 5; s++) begin
      gen_random(100);
      case (s)
        0: run_stream(30, 80);
        1: run_stream(60, 90);
        2: run_stream(100, 100);
        3: run_stream(10, 70);
        default: run_stream(50, 100);
      endcase
      compare_model($sformatf("rand%0d", s));
    end

    nw5 = 0; nb5_last = -1; got5 = 0;
    out_rdy5 = 1'b1;
    for (int i = 0, c = 0; c < 3000 && !got5; c++) begin
      @(negedge clk);
      if (done5) got5 = 1;
      in_val5  = (i <= 150);
      in_cmd5  = (i == 150) ? 2'd2 : 2'd0;
      in_numb5 = (i == 150) ? 5'd0 : 5'd16;
      in_dat5  = 19'($urandom);
      if (in_val5 && in_rdy5) i++;
      if (out_val5) begin
        nw5++;
        if (out_lst5) nb5_last = int'(out_nbyte5);
      end
    end
    in_val5 = 1'b0;
    check("t5_done", got5, 1);
    check("t5_nwords", nw5, 38);
    check("t5_last_nbyte", nb5_last, 4);
    check("t5_byte_cnt", byte_cnt5, 8'(300 % 256));

    tq_cmd.delete(); tq_n.delete(); tq_d.delete();
    for (int i = 0; i < 3; i++) begin
      tq_cmd.push_back(2'd0); tq_n.push_back(19); tq_d.push_back(19'($urandom));
    end
    tq_cmd.push_back(2'd2); tq_n.push_back(0); tq_d.push_back(19'h0);
    feed_tokens(0, 3, 1);
    feed_tokens(3, 4, 0);
    repeat (3) @(negedge clk);
    check("drain_stuck_val", out_val_o, 1);
    check("drain_stuck_rdy", in_rdy_o, 0);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    check_reset("clr");
    exp_bytes = '0;
    gen_random(60);
    run_stream(70, 90);
    compare_model("after_clr");

    tq_cmd.delete(); tq_n.delete(); tq_d.delete();
    for (int i = 0; i < 5; i++) begin
      tq_cmd.push_back(2'd0); tq_n.push_back(17); tq_d.push_back(19'($urandom));
    end
    feed_tokens(0, 5, 1);
    rstn = 1'b0;
    #1;
    check_reset("rstn");
    @(negedge clk);
    rstn = 1'b1;
    exp_bytes = '0;
    gen_random(60);
    run_stream(40, 80);
    compare_model("after_rstn");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
